// File: rtl/fu_br_pipe_if.sv
// fu_br_pipe_if: bundle of the branch unit's issue, result and counter signals.
//   master : issue side (flush, start, decode_info, rs1_v, rs2_v, pd_in,
//            rob_idx_in) and result consumer (out_ready); observes all outputs.
//   slave  : the branch unit; drives ready, valid, rd_v, pd_out, rob_idx_out,
//            pc_select, pc_branch, btb_web, btb_addr, btb_din, lht_in,
//            br_cnt, mispred_cnt.
interface fu_br_pipe_if #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int BTB_IDX_BITS  = 8,
  parameter int LHT_BITS      = 8,
  parameter int CNT_BITS      = 32
);
  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [31:0]         pc;
    logic [31:0]         i_imm;
    logic [31:0]         j_imm;
    logic [31:0]         b_imm;
    logic                bp;
    logic [31:0]         bp_addr;
    logic                lht_valid;
    logic [LHT_BITS-1:0] lht_true;
  } decode_info_t;

  logic                     flush;
  logic                     start;
  logic                     ready;
  decode_info_t             decode_info;
  logic [31:0]              rs1_v;
  logic [31:0]              rs2_v;
  logic [PHYS_REG_BITS-1:0] pd_in;
  logic [ROB_IDX_BITS-1:0]  rob_idx_in;
  logic                     valid;
  logic                     out_ready;
  logic [31:0]              rd_v;
  logic [PHYS_REG_BITS-1:0] pd_out;
  logic [ROB_IDX_BITS-1:0]  rob_idx_out;
  logic                     pc_select;
  logic [31:0]              pc_branch;
  logic                     btb_web;
  logic [BTB_IDX_BITS-1:0]  btb_addr;
  logic [31:0]              btb_din;
  logic [LHT_BITS-1:0]      lht_in;
  logic [CNT_BITS-1:0]      br_cnt;
  logic [CNT_BITS-1:0]      mispred_cnt;

  modport master (
    output flush, start, decode_info, rs1_v, rs2_v, pd_in, rob_idx_in, out_ready,
    input  ready, valid, rd_v, pd_out, rob_idx_out, pc_select, pc_branch,
           btb_web, btb_addr, btb_din, lht_in, br_cnt, mispred_cnt
  );

  modport slave (
    input  flush, start, decode_info, rs1_v, rs2_v, pd_in, rob_idx_in, out_ready,
    output ready, valid, rd_v, pd_out, rob_idx_out, pc_select, pc_branch,
           btb_web, btb_addr, btb_din, lht_in, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/fu_br_pipe.sv
// fu_br_pipe: pipelined branch/jump functional unit.
//   Ops are pushed into a small in-order queue, resolved when they move from
//   the queue head into the result register, and held there until the
//   consumer takes them (valid && out_ready).
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : fu_br_pipe_if.slave (issue, result, BTB/LHT update, counters)
module fu_br_pipe #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int QUEUE_DEPTH   = 4,
  parameter int BTB_IDX_BITS  = 8,
  parameter int LHT_BITS      = 8,
  parameter int CNT_BITS      = 32
) (
  input  logic        clk,
  input  logic        rst,
  fu_br_pipe_if.slave bus
);
  localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [PTR_BITS:0]   DEPTH_CNT = (PTR_BITS+1)'(QUEUE_DEPTH);
  localparam logic [PTR_BITS:0]   CNT_ONE   = (PTR_BITS+1)'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
  localparam logic [CNT_BITS-1:0] PERF_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] PERF_ONE  = CNT_BITS'(1);

  // Queue entry: the opcode is pre-decoded and only the immediate that the
  // op actually uses is kept.
  typedef struct packed {
    logic                     is_jal;
    logic                     is_jalr;
    logic                     is_br;
    logic [2:0]               funct3;
    logic [31:0]              pc;
    logic [31:0]              rs1;
    logic [31:0]              rs2;
    logic [31:0]              imm;
    logic                     bp;
    logic [31:0]              bp_addr;
    logic                     lht_valid;
    logic [LHT_BITS-2:0]      lht_hist;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_IDX_BITS-1:0]  rob;
  } entry_t;

  // Result register; btb_we is stored active-high so the idle value is all zeros.
  typedef struct packed {
    logic                     valid;
    logic                     is_br;
    logic [31:0]              rd_v;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_IDX_BITS-1:0]  rob;
    logic                     pc_select;
    logic [31:0]              pc_branch;
    logic                     btb_we;
    logic [BTB_IDX_BITS-1:0]  btb_addr;
    logic [31:0]              btb_din;
    logic [LHT_BITS-1:0]      lht_in;
  } result_t;

  entry_t              queue_r [QUEUE_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_r;
  logic [PTR_BITS-1:0] rd_ptr_r;
  logic [PTR_BITS:0]   count_r;
  result_t             res_r;
  logic [CNT_BITS-1:0] br_cnt_r;
  logic [CNT_BITS-1:0] mispred_cnt_r;

  entry_t  in_entry_s;
  entry_t  head_s;
  result_t res_nxt_s;
  logic    full_s;
  logic    push_s;
  logic    pop_s;
  logic    hs_s;
  logic    cond_s;
  logic    taken_s;
  logic [31:0] target_s;
  logic    lht_msb_unused_s;

  // The oldest history bit is shifted out and never needed.
  assign lht_msb_unused_s = bus.decode_info.lht_true[LHT_BITS-1];

  // Flush overrides every other queue/result event in its cycle.
  assign full_s = (count_r == DEPTH_CNT);
  assign push_s = bus.start && !full_s && !bus.flush;
  assign pop_s  = (count_r != {(PTR_BITS+1){1'b0}}) && (!res_r.valid || bus.out_ready) && !bus.flush;
  assign hs_s   = res_r.valid && bus.out_ready && !bus.flush;

  // Pre-decode the incoming op into a queue entry.
  always_comb begin
    in_entry_s           = {$bits(entry_t){1'b0}};
    in_entry_s.is_jal    = (bus.decode_info.opcode == OP_JAL);
    in_entry_s.is_jalr   = (bus.decode_info.opcode == OP_JALR);
    in_entry_s.is_br     = (bus.decode_info.opcode == OP_BR);
    in_entry_s.funct3    = bus.decode_info.funct3;
    in_entry_s.pc        = bus.decode_info.pc;
    in_entry_s.rs1       = bus.rs1_v;
    in_entry_s.rs2       = bus.rs2_v;
    in_entry_s.bp        = bus.decode_info.bp;
    in_entry_s.bp_addr   = bus.decode_info.bp_addr;
    in_entry_s.lht_valid = bus.decode_info.lht_valid;
    in_entry_s.lht_hist  = bus.decode_info.lht_true[LHT_BITS-2:0];
    in_entry_s.pd        = bus.pd_in;
    in_entry_s.rob       = bus.rob_idx_in;
    case (bus.decode_info.opcode)
      OP_JAL:  in_entry_s.imm = bus.decode_info.j_imm;
      OP_JALR: in_entry_s.imm = bus.decode_info.i_imm;
      OP_BR:   in_entry_s.imm = bus.decode_info.b_imm;
      default: in_entry_s.imm = 32'd0;
    endcase
  end

  // Resolve the op at the queue head: branch condition, taken, target.
  always_comb begin
    head_s = queue_r[rd_ptr_r];
    case (head_s.funct3)
      3'b000:  cond_s = (head_s.rs1 == head_s.rs2);
      3'b001:  cond_s = (head_s.rs1 != head_s.rs2);
      3'b100:  cond_s = ($signed(head_s.rs1) <  $signed(head_s.rs2));
      3'b101:  cond_s = ($signed(head_s.rs1) >= $signed(head_s.rs2));
      3'b110:  cond_s = (head_s.rs1 <  head_s.rs2);
      3'b111:  cond_s = (head_s.rs1 >= head_s.rs2);
      default: cond_s = 1'b0;
    endcase
    if (head_s.is_jal) begin
      taken_s  = 1'b1;
      target_s = head_s.pc + head_s.imm;
    end else if (head_s.is_jalr) begin
      taken_s  = 1'b1;
      target_s = (head_s.rs1 + head_s.imm) & 32'hFFFF_FFFE;
    end else if (head_s.is_br) begin
      taken_s  = cond_s;
      target_s = head_s.pc + head_s.imm;
    end else begin
      taken_s  = 1'b0;
      target_s = 32'd0;
    end
  end

  // Build the result word for the head op (redirect, BTB, LHT, writeback).
  always_comb begin
    res_nxt_s       = {$bits(result_t){1'b0}};
    res_nxt_s.valid = 1'b1;
    res_nxt_s.is_br = head_s.is_br;
    res_nxt_s.pd    = head_s.pd;
    res_nxt_s.rob   = head_s.rob;
    if (head_s.is_jal || head_s.is_jalr) begin
      res_nxt_s.rd_v = head_s.pc + 32'd4;
    end else begin
      res_nxt_s.rd_v = 32'd0;
    end
    // A correctly predicted taken op needs no redirect; a predicted-taken op
    // that falls through must restart at pc+4.
    if (head_s.bp && taken_s && (head_s.bp_addr == target_s)) begin
      res_nxt_s.pc_select = 1'b0;
      res_nxt_s.pc_branch = 32'd0;
    end else if (head_s.bp && !taken_s) begin
      res_nxt_s.pc_select = 1'b1;
      res_nxt_s.pc_branch = head_s.pc + 32'd4;
    end else if (taken_s) begin
      res_nxt_s.pc_select = 1'b1;
      res_nxt_s.pc_branch = target_s;
    end else begin
      res_nxt_s.pc_select = 1'b0;
      res_nxt_s.pc_branch = 32'd0;
    end
    if (taken_s) begin
      res_nxt_s.btb_we   = 1'b1;
      res_nxt_s.btb_addr = head_s.pc[BTB_IDX_BITS+1:2];
      res_nxt_s.btb_din  = target_s;
    end else begin
      res_nxt_s.btb_we   = 1'b0;
      res_nxt_s.btb_addr = {BTB_IDX_BITS{1'b0}};
      res_nxt_s.btb_din  = 32'd0;
    end
    if (head_s.lht_valid) begin
      res_nxt_s.lht_in = {head_s.lht_hist, taken_s};
    end else begin
      res_nxt_s.lht_in = {{(LHT_BITS-1){1'b0}}, taken_s};
    end
  end

  // Queue storage: data only, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_s) begin
      queue_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {(PTR_BITS+1){1'b0}};
    end else if (bus.flush) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {(PTR_BITS+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Result register: load on pop, clear when consumed or flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_r <= {$bits(result_t){1'b0}};
    end else if (bus.flush) begin
      res_r <= {$bits(result_t){1'b0}};
    end else if (pop_s) begin
      res_r <= res_nxt_s;
    end else if (hs_s) begin
      res_r <= {$bits(result_t){1'b0}};
    end
  end

  // Saturating performance counters, advanced only on a result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_r      <= {CNT_BITS{1'b0}};
      mispred_cnt_r <= {CNT_BITS{1'b0}};
    end else if (hs_s) begin
      if (res_r.is_br && (br_cnt_r != PERF_MAX)) begin
        br_cnt_r <= br_cnt_r + PERF_ONE;
      end
      if (res_r.pc_select && (mispred_cnt_r != PERF_MAX)) begin
        mispred_cnt_r <= mispred_cnt_r + PERF_ONE;
      end
    end
  end

  assign bus.ready       = !full_s;
  assign bus.valid       = res_r.valid;
  assign bus.rd_v        = res_r.rd_v;
  assign bus.pd_out      = res_r.pd;
  assign bus.rob_idx_out = res_r.rob;
  assign bus.pc_select   = res_r.pc_select;
  assign bus.pc_branch   = res_r.pc_branch;
  assign bus.btb_web     = !res_r.btb_we;
  assign bus.btb_addr    = res_r.btb_addr;
  assign bus.btb_din     = res_r.btb_din;
  assign bus.lht_in      = res_r.lht_in;
  assign bus.br_cnt      = br_cnt_r;
  assign bus.mispred_cnt = mispred_cnt_r;
endmodule

// File: tb/tb_fu_br_pipe.sv
// tb_fu_br_pipe: directed table, hand-written corner sequences and random
// traffic for fu_br_pipe, all checked against a transaction-level model.
module tb_fu_br_pipe;
  localparam int PRB = 6;
  localparam int RIB = 5;
  localparam int QD  = 4;
  localparam int BIB = 8;
  localparam int LB  = 8;
  localparam int CB  = 4;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fu_br_pipe_if #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB), .BTB_IDX_BITS(BIB),
                  .LHT_BITS(LB), .CNT_BITS(CB)) bus ();

  fu_br_pipe #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB), .QUEUE_DEPTH(QD),
               .BTB_IDX_BITS(BIB), .LHT_BITS(LB), .CNT_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc, i_imm, j_imm, b_imm, rs1, rs2, bp_addr;
    logic        bp, lht_valid;
    logic [7:0]  lht_true;
    logic [5:0]  pd;
    logic [4:0]  rob;
  } op_t;

  typedef struct {
    logic [31:0] rd_v, pc_branch, btb_din;
    logic        pc_select, btb_web, is_br;
    logic [7:0]  btb_addr, lht_in;
    logic [5:0]  pd;
    logic [4:0]  rob;
  } res_t;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc, imm, rs1, rs2;
    logic        bp;
    logic [31:0] bp_addr;
    logic        lht_valid;
    logic [7:0]  lht_true;
    logic [31:0] e_rd_v;
    logic        e_sel;
    logic [31:0] e_branch;
    logic        e_web;
    logic [7:0]  e_addr;
    logic [31:0] e_din;
    logic [7:0]  e_lht;
  } tv_t;

  int   tests  = 0;
  int   failed = 0;
  res_t mq[$];
  res_t mres;
  res_t cur_res;
  bit   mvalid;
  int   m_br;
  int   m_mis;
  tv_t  tv [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of one op, straight from the architectural rules.
  function automatic res_t ref_resolve(input op_t o);
    res_t r;
    bit taken = 1'b0;
    logic [31:0] target = 32'd0;
    if (o.opcode == OP_JAL) begin
      taken = 1'b1; target = o.pc + o.j_imm;
    end else if (o.opcode == OP_JALR) begin
      taken = 1'b1; target = (o.rs1 + o.i_imm) & ~32'd1;
    end else if (o.opcode == OP_BR) begin
      target = o.pc + o.b_imm;
      case (o.funct3)
        3'd0: taken = (o.rs1 == o.rs2);
        3'd1: taken = (o.rs1 != o.rs2);
        3'd4: taken = (int'(o.rs1) <  int'(o.rs2));
        3'd5: taken = (int'(o.rs1) >= int'(o.rs2));
        3'd6: taken = (o.rs1 <  o.rs2);
        3'd7: taken = (o.rs1 >= o.rs2);
        default: taken = 1'b0;
      endcase
    end
    r.is_br = (o.opcode == OP_BR);
    r.rd_v  = (o.opcode == OP_JAL || o.opcode == OP_JALR) ? o.pc + 32'd4 : 32'd0;
    if (o.bp && taken && o.bp_addr == target) begin
      r.pc_select = 1'b0; r.pc_branch = 32'd0;
    end else if (o.bp && !taken) begin
      r.pc_select = 1'b1; r.pc_branch = o.pc + 32'd4;
    end else begin
      r.pc_select = taken; r.pc_branch = taken ? target : 32'd0;
    end
    r.btb_web  = !taken;
    r.btb_addr = taken ? o.pc[9:2] : 8'd0;
    r.btb_din  = taken ? target : 32'd0;
    r.lht_in   = o.lht_valid ? {o.lht_true[6:0], taken} : {7'd0, taken};
    r.pd  = o.pd;
    r.rob = o.rob;
    return r;
  endfunction

  task automatic set_op(input op_t o);
    bus.decode_info.opcode    = o.opcode;
    bus.decode_info.funct3    = o.funct3;
    bus.decode_info.pc        = o.pc;
    bus.decode_info.i_imm     = o.i_imm;
    bus.decode_info.j_imm     = o.j_imm;
    bus.decode_info.b_imm     = o.b_imm;
    bus.decode_info.bp        = o.bp;
    bus.decode_info.bp_addr   = o.bp_addr;
    bus.decode_info.lht_valid = o.lht_valid;
    bus.decode_info.lht_true  = o.lht_true;
    bus.rs1_v      = o.rs1;
    bus.rs2_v      = o.rs2;
    bus.pd_in      = o.pd;
    bus.rob_idx_in = o.rob;
    cur_res        = ref_resolve(o);
  endtask

  function automatic op_t tv_op(input tv_t t, input int n);
    op_t o;
    o.opcode = t.opcode; o.funct3 = t.funct3; o.pc = t.pc;
    o.i_imm = (t.opcode == OP_JALR) ? t.imm : 32'h5A5A_0101;
    o.j_imm = (t.opcode == OP_JAL)  ? t.imm : 32'h0606_0600;
    o.b_imm = (t.opcode == OP_BR)   ? t.imm : 32'h0000_7770;
    o.rs1 = t.rs1; o.rs2 = t.rs2; o.bp = t.bp; o.bp_addr = t.bp_addr;
    o.lht_valid = t.lht_valid; o.lht_true = t.lht_true;
    o.pd = 6'(n + 1); o.rob = 5'(n + 2);
    return o;
  endfunction

  function automatic op_t rand_op(input int n);
    op_t o;
    case ($urandom_range(0, 5))
      0: o.opcode = OP_JAL;
      1: o.opcode = OP_JALR;
      2, 3, 4: o.opcode = OP_BR;
      default: o.opcode = 7'h33;
    endcase
    o.funct3 = 3'($urandom_range(0, 7));
    o.pc     = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
    o.i_imm  = 32'($urandom_range(0, 511)) - 32'd256;
    o.j_imm  = {20'd0, 11'($urandom_range(0, 2047)), 1'b0};
    o.b_imm  = 32'($urandom_range(0, 1023)) - 32'd512;
    o.rs1    = $urandom;
    o.rs2    = ($urandom_range(0, 2) == 0) ? o.rs1 : $urandom;
    o.bp     = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0: o.bp_addr = o.pc + o.b_imm;
      1: o.bp_addr = o.pc + o.j_imm;
      default: o.bp_addr = $urandom;
    endcase
    o.lht_valid = 1'($urandom_range(0, 1));
    o.lht_true  = 8'($urandom_range(0, 255));
    o.pd  = 6'(n);
    o.rob = 5'(n);
    return o;
  endfunction

  // Mispredicting beq (equal operands, not predicted).
  function automatic op_t mis_op(input int n);
    op_t o;
    o = rand_op(n);
    o.opcode = OP_BR; o.funct3 = 3'd0; o.rs2 = o.rs1; o.bp = 1'b0;
    return o;
  endfunction

  // Apply the inputs currently on the bus to the model for the coming edge.
  task automatic model_edge();
    bit hs, full, pop, push;
    if (bus.flush) begin
      mq.delete();
      mvalid = 1'b0;
    end else begin
      hs   = mvalid && bus.out_ready;
      full = (mq.size() == QD);
      pop  = (mq.size() > 0) && (!mvalid || bus.out_ready);
      push = bus.start && !full;
      if (hs) begin
        if (mres.is_br && m_br < 15) m_br++;
        if (mres.pc_select && m_mis < 15) m_mis++;
      end
      if (pop) begin
        mres = mq.pop_front(); mvalid = 1'b1;
      end else if (hs) begin
        mvalid = 1'b0;
      end
      if (push) mq.push_back(cur_res);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mvalid = 1'b0; m_br = 0; m_mis = 0;
  endtask

  task automatic check_all(input string tag);
    res_t e;
    if (mvalid) begin
      e = mres;
    end else begin
      e.rd_v = 32'd0; e.pc_branch = 32'd0; e.btb_din = 32'd0; e.pc_select = 1'b0;
      e.btb_web = 1'b1; e.btb_addr = 8'd0; e.lht_in = 8'd0; e.pd = 6'd0; e.rob = 5'd0;
      e.is_br = 1'b0;
    end
    chk({tag, ".valid"},     32'(bus.valid),       32'(mvalid));
    chk({tag, ".ready"},     32'(bus.ready),       32'(mq.size() < QD));
    chk({tag, ".br_cnt"},    32'(bus.br_cnt),      32'(m_br));
    chk({tag, ".mis_cnt"},   32'(bus.mispred_cnt), 32'(m_mis));
    chk({tag, ".rd_v"},      bus.rd_v,             e.rd_v);
    chk({tag, ".pd"},        32'(bus.pd_out),      32'(e.pd));
    chk({tag, ".rob"},       32'(bus.rob_idx_out), 32'(e.rob));
    chk({tag, ".pc_select"}, 32'(bus.pc_select),   32'(e.pc_select));
    chk({tag, ".pc_branch"}, bus.pc_branch,        e.pc_branch);
    chk({tag, ".btb_web"},   32'(bus.btb_web),     32'(e.btb_web));
    chk({tag, ".btb_addr"},  32'(bus.btb_addr),    32'(e.btb_addr));
    chk({tag, ".btb_din"},   bus.btb_din,          e.btb_din);
    chk({tag, ".lht_in"},    32'(bus.lht_in),      32'(e.lht_in));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".valid"},     32'(bus.valid),       32'd0);
    chk({tag, ".ready"},     32'(bus.ready),       32'd1);
    chk({tag, ".pc_select"}, 32'(bus.pc_select),   32'd0);
    chk({tag, ".pc_branch"}, bus.pc_branch,        32'd0);
    chk({tag, ".btb_web"},   32'(bus.btb_web),     32'd1);
    chk({tag, ".btb_addr"},  32'(bus.btb_addr),    32'd0);
    chk({tag, ".btb_din"},   bus.btb_din,          32'd0);
    chk({tag, ".lht_in"},    32'(bus.lht_in),      32'd0);
    chk({tag, ".rd_v"},      bus.rd_v,             32'd0);
    chk({tag, ".br_cnt"},    32'(bus.br_cnt),      32'd0);
    chk({tag, ".mis_cnt"},   32'(bus.mispred_cnt), 32'd0);
  endtask

  initial begin
    //        opcode  f3    pc          imm           rs1           rs2           bp    bp_addr       lv    lht     rd_v          sel   branch        web   addr   din           lht
    tv[0] = '{OP_BR,  3'd0, 32'h100, 32'h20,       32'd5,        32'd5,        1'b0, 32'h0,        1'b0, 8'h00, 32'h0,        1'b1, 32'h120,      1'b0, 8'h40, 32'h120,      8'h01};
    tv[1] = '{OP_JAL, 3'd0, 32'h200, 32'h40,       32'd0,        32'd0,        1'b1, 32'h240,      1'b0, 8'h00, 32'h204,      1'b0, 32'h0,        1'b0, 8'h80, 32'h240,      8'h01};
    tv[2] = '{OP_JAL, 3'd0, 32'h200, 32'h40,       32'd0,        32'd0,        1'b1, 32'h300,      1'b0, 8'h00, 32'h204,      1'b1, 32'h240,      1'b0, 8'h80, 32'h240,      8'h01};
    tv[3] = '{OP_BR,  3'd6, 32'h300, 32'h10,       32'hFFFFFFFF, 32'd1,        1'b1, 32'h0,        1'b1, 8'h55, 32'h0,        1'b1, 32'h304,      1'b1, 8'h00, 32'h0,        8'hAA};
    tv[4] = '{OP_BR,  3'd4, 32'h400, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,        1'b0, 8'h00, 32'h0,        1'b1, 32'h3F0,      1'b0, 8'h00, 32'h3F0,      8'h01};
    tv[5] = '{OP_JALR,3'd0, 32'h500, 32'h4,        32'h1001,     32'd0,        1'b1, 32'h1004,     1'b1, 8'h80, 32'h504,      1'b0, 32'h0,        1'b0, 8'h40, 32'h1004,     8'h01};
    tv[6] = '{7'h13,  3'd0, 32'h600, 32'h8,        32'd1,        32'd2,        1'b0, 32'h0,        1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        1'b1, 8'h00, 32'h0,        8'h00};
    tv[7] = '{OP_BR,  3'd5, 32'h700, 32'h8,        32'd5,        32'd5,        1'b1, 32'h708,      1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        1'b0, 8'hC0, 32'h708,      8'h01};
    tv[8] = '{OP_BR,  3'd1, 32'h800, 32'h8,        32'd3,        32'd3,        1'b0, 32'h0,        1'b1, 8'h03, 32'h0,        1'b0, 32'h0,        1'b1, 8'h00, 32'h0,        8'h06};
    tv[9] = '{OP_BR,  3'd7, 32'h900, 32'h8,        32'd1,        32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        1'b1, 8'h00, 32'h0,        8'h00};

    rst = 1'b1;
    bus.flush = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    set_op(rand_op(0));
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("post_reset");

    // Directed table: one op at a time through an idle unit.
    for (int i = 0; i < 10; i++) begin
      set_op(tv_op(tv[i], i));
      bus.start = 1'b1; bus.out_ready = 1'b1;
      cycle("tv_push");
      chk($sformatf("tv%0d.lat_valid0", i), 32'(bus.valid), 32'd0);
      bus.start = 1'b0;
      cycle("tv_res");
      chk($sformatf("tv%0d.valid", i),     32'(bus.valid),       32'd1);
      chk($sformatf("tv%0d.rd_v", i),      bus.rd_v,             tv[i].e_rd_v);
      chk($sformatf("tv%0d.pc_select", i), 32'(bus.pc_select),   32'(tv[i].e_sel));
      chk($sformatf("tv%0d.pc_branch", i), bus.pc_branch,        tv[i].e_branch);
      chk($sformatf("tv%0d.btb_web", i),   32'(bus.btb_web),     32'(tv[i].e_web));
      chk($sformatf("tv%0d.btb_addr", i),  32'(bus.btb_addr),    32'(tv[i].e_addr));
      chk($sformatf("tv%0d.btb_din", i),   bus.btb_din,          tv[i].e_din);
      chk($sformatf("tv%0d.lht_in", i),    32'(bus.lht_in),      32'(tv[i].e_lht));
      chk($sformatf("tv%0d.rob", i),       32'(bus.rob_idx_out), 32'(i + 2));
      chk($sformatf("tv%0d.pd", i),        32'(bus.pd_out),      32'(i + 1));
      cycle("tv_drain");
    end
    chk("tv.br_cnt",  32'(bus.br_cnt),      32'd6);
    chk("tv.mis_cnt", 32'(bus.mispred_cnt), 32'd4);

    // Fill: stall the consumer and offer six ops; only five fit.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_op(rand_op(10 + k));
      bus.start = 1'b1;
      cycle("fill");
    end
    bus.start = 1'b0;
    chk("fill.ready", 32'(bus.ready), 32'd0);
    chk("fill.head_rob", 32'(bus.rob_idx_out), 32'd10);
    for (int k = 0; k < 3; k++) begin
      cycle("stall");
      chk("stall.rob", 32'(bus.rob_idx_out), 32'd10);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle("drain");
      chk("drain.valid", 32'(bus.valid), 32'd1);
      chk("drain.rob", 32'(bus.rob_idx_out), 32'(11 + k));
    end
    cycle("drain_end");
    chk("drain.empty", 32'(bus.valid), 32'd0);

    // Flush with one result held and three queued; start in the flush cycle is dropped.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_op(mis_op(k));
      bus.start = 1'b1;
      cycle("pre_flush");
    end
    begin
      int br_before, mis_before;
      br_before = m_br; mis_before = m_mis;
      chk("pre_flush.valid", 32'(bus.valid), 32'd1);
      set_op(mis_op(7));
      bus.flush = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
      cycle("flush");
      bus.flush = 1'b0; bus.start = 1'b0;
      chk("flush.valid",   32'(bus.valid),       32'd0);
      chk("flush.ready",   32'(bus.ready),       32'd1);
      chk("flush.br_cnt",  32'(bus.br_cnt),      32'(br_before));
      chk("flush.mis_cnt", 32'(bus.mispred_cnt), 32'(mis_before));
      cycle("post_flush");
      cycle("post_flush");
      chk("flush.dropped", 32'(bus.valid), 32'd0);
    end

    // Random traffic with occasional flushes and consumer stalls.
    for (int c = 0; c < 400; c++) begin
      bus.flush     = ($urandom_range(0, 31) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.start     = 1'($urandom_range(0, 1));
      set_op(rand_op(c));
      cycle("rand");
    end
    bus.flush = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle("rand_drain");

    // Saturation: push enough mispredicts to pin both 4-bit counters.
    for (int k = 0; k < 17; k++) begin
      set_op(mis_op(k));
      bus.start = 1'b1;
      cycle("sat");
    end
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) cycle("sat_drain");
    chk("sat.mis_cnt", 32'(bus.mispred_cnt), 32'd15);
    chk("sat.br_cnt",  32'(bus.br_cnt),      32'd15);
    set_op(mis_op(3));
    bus.start = 1'b1;
    cycle("sat_more");
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) cycle("sat_more_drain");
    chk("sat.hold", 32'(bus.mispred_cnt), 32'd15);

    // Asynchronous reset in the middle of a stall.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_op(mis_op(k));
      bus.start = 1'b1;
      cycle("pre_rst");
    end
    bus.start = 1'b0;
    chk("pre_rst.valid", 32'(bus.valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cycle("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fu_br_pipe.md
Name: fu_br_pipe

Overview:
- Pipelined, buffered successor to the single-cycle branch functional unit. Accepts branch/jump ops from the reservation station into a small in-order queue, resolves them one stage later, and presents a registered result to the CDB/ROB side with a ready/valid stall.
- Per result: rd writeback value for jal/jalr, redirect decision against the front-end prediction, BTB write request, LHT update word.
- Adds flush support and saturating branch/mispredict performance counters.

Parameters:
- PHYS_REG_BITS, 6, width of the destination physical register tag.
- ROB_IDX_BITS, 5, width of the ROB index carried with each op.
- QUEUE_DEPTH, 4, input queue entries; power of two, at least 2.
- BTB_IDX_BITS, 8, BTB index width; index is pc[BTB_IDX_BITS+1:2].
- LHT_BITS, 8, local history width.
- CNT_BITS, 32, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  kill all queued and in-flight ops.
- start  in  1  issue valid.
- ready  out  1  queue can accept; equals not full.
- decode_info  in  decode_info_t  opcode, funct3, pc, i/j/b_imm, bp, bp_addr, lht_valid, lht_true.
- rs1_v, rs2_v  in  32 each  operand values.
- pd_in  in  PHYS_REG_BITS  destination tag.
- rob_idx_in  in  ROB_IDX_BITS  ROB index.
- valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- rd_v  out  32  pc+4 for jal/jalr, 0 otherwise.
- pd_out, rob_idx_out  out  tag and ROB index of the result.
- pc_select  out  1  redirect required.
- pc_branch  out  32  redirect target, 0 when pc_select=0.
- btb_web  out  1  active-low BTB write enable.
- btb_addr  out  BTB_IDX_BITS  BTB index.
- btb_din  out  32  BTB data.
- lht_in  out  LHT_BITS  LHT update word.
- br_cnt, mispred_cnt  out  CNT_BITS each  performance counters.

Behaviour:
- Reset: queue empty, result register invalid, counters 0.
  - Outputs during reset: valid=0, ready=1, pc_select=0, pc_branch=0, btb_web=1, btb_addr=0, btb_din=0, lht_in=0, rd_v=0.
- Queue:
  - Push on start&&ready. ready = !full, so no push when full even if a pop occurs the same cycle.
  - Pointers wrap modulo QUEUE_DEPTH. Occupancy counter is one bit wider than the pointers.
- Pop condition: the head moves into the execute/result register when the queue is non-empty and (!valid || out_ready).
- Latency: op accepted at edge T appears with valid=1 in cycle T+2 (empty unit, no stalls). Throughput is 1 op/cycle.
- Stall: while valid && !out_ready, all result outputs hold stable and the queue keeps filling.
- Resolution at pop time, registered:
  - jal: taken, target pc+j_imm.
  - jalr: taken, target (rs1+i_imm) & ~1.
  - br: compare per funct3 (beq/bne/blt/bge signed, bltu/bgeu unsigned); target pc+b_imm.
  - Other opcodes: not taken, rd_v=0.
- Redirect rules:
  - bp && taken && bp_addr==target: pc_select=0.
  - bp && !taken: pc_select=1, pc_branch=pc+4.
  - Otherwise: pc_select=taken, pc_branch=target when taken, else 0.
- BTB: when taken, btb_web=0, btb_addr=pc index, btb_din=target. Otherwise btb_web=1 with addr/din 0.
- lht_in = {lht_true[LHT_BITS-2:0], taken} if lht_valid, else {0…, taken}.
- All result fields other than valid are 0 whenever valid=0.
- Counters update on a result handshake (valid&&out_ready):
  - br_cnt += 1 for op_b_br.
  - mispred_cnt += 1 when pc_select=1.
  - Both saturate at all-ones and are not cleared by flush.
- Flush takes priority over start, pop and handshake:
  - Queue is emptied and the result register invalidated at that edge; valid=0 the next cycle.
  - start in the flush cycle is dropped; a result presented in the flush cycle is not counted.
- rst asserted mid-operation clears everything immediately (asynchronous), independent of clk.

Test Plan:
- beq rs1=rs2=5, pc=0x100, b_imm=0x20, bp=0: accepted T -> valid at T+2, pc_select=1, pc_branch=0x120, btb_web=0, btb_addr=0x40, btb_din=0x120, mispred_cnt=1, br_cnt=1.
- jal pc=0x200, j_imm=0x40, bp=1, bp_addr=0x240 -> rd_v=0x204, pc_select=0, btb_din=0x240, lht_in[0]=1. Same with bp_addr=0x300 -> pc_select=1, pc_branch=0x240.
- bltu rs1=0xFFFFFFFF, rs2=1, bp=1, lht_valid=1, lht_true=0x55 -> not taken, pc_select=1, pc_branch=pc+4, btb_web=1, lht_in=0xAA.
- Fill: hold out_ready=0, issue 5 ops -> ready=0 after 4 queued plus 1 in the result register. Outputs stable while stalled; releasing drains in order, 1/cycle, matching rob_idx sequence.
- Flush with 3 queued and valid=1 -> next cycle valid=0, ready=1, counters unchanged. start during flush is not executed.
- Force mispred_cnt to all-ones (CNT_BITS=4 build: 15), one more mispredict -> stays 15. Assert rst mid-stall -> outputs at reset values before the next clk edge.
